// File: rtl/user_id_matcher.sv
// Purpose : collect an N-digit user ID, scan the ID ROM entry by entry, report the matching index.
// Latency : match on entry k reported (k+1)*(DIGITS*(ROM_LAT+2)+1)+1 clocks after the last digit.
// Backpr. : none; single-cycle strobes, Game_Enter ignored while scanning/matched/locked.
module user_id_matcher #(
  parameter int DIGITS      = 4,
  parameter int DIGIT_W     = 4,
  parameter int NUM_IDS     = 8,
  parameter int ADDR_W      = 5,
  parameter int ID_W        = 5,
  parameter int ROM_LAT     = 2,
  parameter logic [DIGITS*DIGIT_W-1:0] GUEST_ID = '0,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Game_Enter,
  input  logic [DIGIT_W-1:0] User_digit,
  input  logic               LogOut,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DIGIT_W-1:0] rom_q,
  output logic               MatchedID,
  output logic [ID_W-1:0]    InternalID,
  output logic               Guest,
  output logic               NoMatch,
  output logic               Locked,
  output logic               Busy
);

  localparam int ID_BITS = DIGITS * DIGIT_W;
  localparam int DCNT_W  = $clog2(DIGITS + 1);
  localparam int WAIT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int TMR_W   = $clog2(LOCK_CYCLES + 1);

  localparam logic [DCNT_W-1:0] LAST_DIGIT = DCNT_W'(DIGITS - 1);
  localparam logic [ID_W-1:0]   LAST_ENTRY = ID_W'(NUM_IDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'((ROM_LAT > 0) ? ROM_LAT - 1 : 0);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);
  localparam logic [TMR_W-1:0]  LOCK_LOAD  = TMR_W'(LOCK_CYCLES);

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_FETCH,
    ST_WAIT,
    ST_CATCH,
    ST_COMPARE,
    ST_MATCHED,
    ST_FAIL,
    ST_LOCKED
  } state_t;

  state_t              state;
  logic [ID_BITS-1:0]  user_id;
  logic [ID_BITS-1:0]  rom_id;
  logic [DCNT_W-1:0]   dcnt;      // digits accepted so far in ENTRY
  logic [DCNT_W-1:0]   digit;     // digit index within the ROM entry being read
  logic [ID_W-1:0]     entry;     // ROM entry under scan
  logic [WAIT_W-1:0]   wait_cnt;
  logic [FAIL_W-1:0]   fail_cnt;
  logic [TMR_W-1:0]    lock_tmr;

  logic [ID_BITS-1:0]  user_next;
  logic [ID_BITS-1:0]  rom_next;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [FAIL_W-1:0]   fail_inc;
  logic                scanning;

  // Shift-in values, ROM address of the current digit and scan-state decode
  assign user_next  = {user_id[ID_BITS-DIGIT_W-1:0], User_digit};
  assign rom_next   = {rom_id[ID_BITS-DIGIT_W-1:0], rom_q};
  assign fetch_addr = ADDR_W'(32'(entry) * 32'(DIGITS) + 32'(digit));
  assign fail_inc   = fail_cnt + FAIL_W'(1);
  assign scanning   = (state == ST_FETCH) || (state == ST_WAIT) ||
                      (state == ST_CATCH) || (state == ST_COMPARE);
  assign Busy       = (state != ST_ENTRY) && (state != ST_MATCHED);

  // Main FSM: digit entry, ROM scan, match/fail reporting and lockout, all outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_ENTRY;
      user_id    <= '0;
      rom_id     <= '0;
      dcnt       <= '0;
      digit      <= '0;
      entry      <= '0;
      wait_cnt   <= '0;
      fail_cnt   <= '0;
      lock_tmr   <= '0;
      rom_addr   <= '0;
      MatchedID  <= 1'b0;
      InternalID <= '0;
      Guest      <= 1'b0;
      NoMatch    <= 1'b0;
      Locked     <= 1'b0;
    end else begin
      NoMatch <= 1'b0;
      if (LogOut && scanning) begin
        // Abort: drop the lookup silently, fail count untouched
        state    <= ST_ENTRY;
        user_id  <= '0;
        rom_id   <= '0;
        dcnt     <= '0;
        digit    <= '0;
        entry    <= '0;
        wait_cnt <= '0;
        rom_addr <= '0;
      end else begin
        case (state)
          ST_ENTRY: begin
            if (LogOut) begin
              // LogOut outranks a simultaneous digit strobe
              user_id <= '0;
              dcnt    <= '0;
            end else if (Game_Enter) begin
              user_id <= user_next;
              if (dcnt == LAST_DIGIT) begin
                dcnt   <= '0;
                entry  <= '0;
                digit  <= '0;
                rom_id <= '0;
                state  <= ST_FETCH;
              end else begin
                dcnt <= dcnt + DCNT_W'(1);
              end
            end
          end

          ST_FETCH: begin
            rom_addr <= fetch_addr;
            wait_cnt <= '0;
            if (ROM_LAT == 0) begin
              state <= ST_CATCH;
            end else begin
              state <= ST_WAIT;
            end
          end

          ST_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
              state <= ST_CATCH;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end

          ST_CATCH: begin
            rom_id <= rom_next;
            if (digit == LAST_DIGIT) begin
              state <= ST_COMPARE;
            end else begin
              digit <= digit + DCNT_W'(1);
              state <= ST_FETCH;
            end
          end

          ST_COMPARE: begin
            if (user_id == rom_id) begin
              state <= ST_MATCHED;
            end else if ((&rom_id) || (entry == LAST_ENTRY)) begin
              // End marker or last scannable entry reached
              state <= ST_FAIL;
            end else begin
              entry  <= entry + ID_W'(1);
              digit  <= '0;
              rom_id <= '0;
              state  <= ST_FETCH;
            end
          end

          ST_MATCHED: begin
            if (LogOut) begin
              MatchedID  <= 1'b0;
              InternalID <= '0;
              Guest      <= 1'b0;
              user_id    <= '0;
              dcnt       <= '0;
              state      <= ST_ENTRY;
            end else begin
              // Re-registered every cycle; values are stable while logged in
              MatchedID  <= 1'b1;
              InternalID <= entry;
              Guest      <= (rom_id == GUEST_ID);
              fail_cnt   <= '0;
            end
          end

          ST_FAIL: begin
            NoMatch  <= 1'b1;
            fail_cnt <= fail_inc;
            user_id  <= '0;
            dcnt     <= '0;
            if (fail_inc == FAIL_LIMIT) begin
              lock_tmr <= LOCK_LOAD;
              Locked   <= 1'b1;
              state    <= ST_LOCKED;
            end else begin
              state <= ST_ENTRY;
            end
          end

          ST_LOCKED: begin
            lock_tmr <= lock_tmr - TMR_W'(1);
            if (lock_tmr <= TMR_W'(1)) begin
              Locked   <= 1'b0;
              fail_cnt <= '0;
              state    <= ST_ENTRY;
            end
          end

          default: state <= ST_ENTRY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_user_id_matcher.sv
// Purpose : self-checking bench for user_id_matcher with a 2-cycle synchronous ROM model.
// Latency : expected lookup latencies come from (k+1)*17+1 for the default parameters.
// Backpr. : none; stimulus strobes are single-cycle.
module tb_user_id_matcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       Game_Enter;
  logic [3:0] User_digit;
  logic       LogOut;
  logic [4:0] rom_addr;
  logic [3:0] rom_q;
  logic       MatchedID;
  logic [4:0] InternalID;
  logic       Guest;
  logic       NoMatch;
  logic       Locked;
  logic       Busy;

  logic [3:0] mem [0:31];
  logic [3:0] q1;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic [15:0] uid;
    logic        matched;
    logic [4:0]  id;
    logic        guest;
    int          lat;
  } vec_t;

  typedef struct {
    logic       matched;
    logic [4:0] id;
    logic       guest;
    int         lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[4];

  user_id_matcher dut (
    .clk        (clk),
    .rst        (rst),
    .Game_Enter (Game_Enter),
    .User_digit (User_digit),
    .LogOut     (LogOut),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .MatchedID  (MatchedID),
    .InternalID (InternalID),
    .Guest      (Guest),
    .NoMatch    (NoMatch),
    .Locked     (Locked),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    q1    <= mem[rom_addr];
    rom_q <= q1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({MatchedID, InternalID, Guest, NoMatch, Locked, Busy});
  endfunction

  task automatic set_entry(input int e, input logic [15:0] v);
    for (int d = 0; d < 4; d++) mem[e*4 + d] = v[(3-d)*4 +: 4];
  endtask

  task automatic press(input logic [3:0] d);
    User_digit = d;
    Game_Enter = 1'b1;
    tick();
    Game_Enter = 1'b0;
  endtask

  task automatic logout();
    LogOut = 1'b1;
    tick();
    LogOut = 1'b0;
  endtask

  // Enter a 4-digit ID, queue the expectation, wait for the result and score it
  task automatic run_lookup(input logic [15:0] uid, input exp_t e);
    int   acc;
    int   n;
    logic seen;
    exp_t got;
    for (int i = 3; i >= 0; i--) press(uid[i*4 +: 4]);
    acc = cyc;
    sb.push_back(e);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 400) begin
      tick();
      n++;
      if (MatchedID || NoMatch) seen = 1'b1;
    end
    got = sb.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL lookup_timeout: no MatchedID/NoMatch for id 0x%04h within %0d cycles, expected after %0d", uid, n, got.lat);
    end else begin
      check("result_matched", 32'(MatchedID), 32'(got.matched));
      check("result_nomatch", 32'(NoMatch), 32'(!got.matched));
      check("internal_id", 32'(InternalID), 32'(got.id));
      check("guest", 32'(Guest), 32'(got.guest));
      check("latency", 32'(cyc - acc), 32'(got.lat));
    end
  endtask

  initial begin
    int   n;
    logic flag;
    exp_t e;

    rst        = 1'b0;
    Game_Enter = 1'b0;
    LogOut     = 1'b0;
    User_digit = 4'h0;
    for (int a = 0; a < 32; a++) mem[a] = 4'hA;
    set_entry(0, 16'h0000);
    set_entry(1, 16'h1234);
    set_entry(2, 16'hFFFF);

    vecs[0] = '{uid: 16'h1234, matched: 1'b1, id: 5'd1, guest: 1'b0, lat: 35};
    vecs[1] = '{uid: 16'h0000, matched: 1'b1, id: 5'd0, guest: 1'b1, lat: 18};
    vecs[2] = '{uid: 16'h9999, matched: 1'b0, id: 5'd0, guest: 1'b0, lat: 52};
    vecs[3] = '{uid: 16'h1234, matched: 1'b1, id: 5'd1, guest: 1'b0, lat: 35};

    tick();
    tick();
    check("reset_outputs", outs(), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    rst = 1'b1;
    tick();

    // Table-driven lookups
    for (int i = 0; i < 4; i++) begin
      e = '{matched: vecs[i].matched, id: vecs[i].id, guest: vecs[i].guest, lat: vecs[i].lat};
      run_lookup(vecs[i].uid, e);
      if (vecs[i].matched) begin
        press(4'h7);
        check("matched_ignores_digit", outs(), 32'({1'b1, vecs[i].id, vecs[i].guest, 3'b000}));
        logout();
        check("logout_clears", outs(), 32'd0);
      end else begin
        tick();
        check("nomatch_one_cycle", outs(), 32'd0);
      end
    end

    // Three consecutive failures lock the block out
    run_lookup(16'h9999, '{matched: 1'b0, id: 5'd0, guest: 1'b0, lat: 52});
    tick();
    check("fail1_idle", outs(), 32'd0);
    run_lookup(16'h8888, '{matched: 1'b0, id: 5'd0, guest: 1'b0, lat: 52});
    tick();
    check("fail2_idle", outs(), 32'd0);
    run_lookup(16'h7777, '{matched: 1'b0, id: 5'd0, guest: 1'b0, lat: 52});
    check("lock_set", 32'({Locked, Busy}), 32'b11);
    n = 0;
    while (Locked && n < 100) begin
      n++;
      if (n % 3 == 1) press(4'h1);
      else tick();
    end
    check("lock_duration", 32'(n), 32'd16);
    check("lock_released", outs(), 32'd0);
    run_lookup(16'h1234, '{matched: 1'b1, id: 5'd1, guest: 1'b0, lat: 35});
    logout();

    // LogOut five cycles into a scan aborts silently
    for (int i = 3; i >= 0; i--) press(vecs[0].uid[i*4 +: 4]);
    repeat (5) tick();
    check("scan_busy", 32'(Busy), 32'd1);
    logout();
    check("abort_not_busy", 32'({Busy, NoMatch}), 32'd0);
    flag = 1'b0;
    repeat (60) begin
      tick();
      if (MatchedID || NoMatch || Busy) flag = 1'b1;
    end
    check("abort_quiet", 32'(flag), 32'd0);
    run_lookup(16'h1234, '{matched: 1'b1, id: 5'd1, guest: 1'b0, lat: 35});
    logout();

    // Reset while matched as guest
    run_lookup(16'h0000, '{matched: 1'b1, id: 5'd0, guest: 1'b1, lat: 18});
    rst = 1'b0;
    tick();
    check("rst_matched_outputs", outs(), 32'd0);
    check("rst_matched_rom_addr", 32'(rom_addr), 32'd0);
    rst = 1'b1;
    repeat (3) tick();
    check("rst_no_residue", outs(), 32'd0);

    // Game_Enter and LogOut together: the digit is dropped
    press(4'h1);
    press(4'h2);
    press(4'h3);
    User_digit = 4'h4;
    Game_Enter = 1'b1;
    LogOut     = 1'b1;
    tick();
    Game_Enter = 1'b0;
    LogOut     = 1'b0;
    tick();
    check("both_strobes_no_scan", 32'(Busy), 32'd0);
    run_lookup(16'h1234, '{matched: 1'b1, id: 5'd1, guest: 1'b0, lat: 35});
    logout();

    // No end marker: the scan stops at the last entry
    for (int k = 2; k < 8; k++) set_entry(k, {4{4'(k)}});
    run_lookup(16'h7777, '{matched: 1'b1, id: 5'd7, guest: 1'b0, lat: 137});
    logout();
    run_lookup(16'h9999, '{matched: 1'b0, id: 5'd0, guest: 1'b0, lat: 137});
    tick();
    check("bound_fail_idle", outs(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
